i2s_clk_gen: RTL

Parametrised I2S/TDM bit-clock and frame-clock generator running in the MCLK domain. It replaces the fixed divide-by-8 / divide-by-512 generator. It adds configurable SCLK ratio, slot width and slot count, plus selectable I2S, left-justified and TDM framing. It also emits single-cycle position strobes so the serializer and deserializer can run in the same MCLK domain without sampling SCLK as data.

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_sclk_div.sv | 74 +++++++
 rtl/i2s_clk_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default ratios for the I2S/TDM clock generator.
// i2s_fmt_e  : frame format select (I2S, left-justified, TDM, reserved)
// i2s_state_e: generator run state
package i2s_pkg;

  typedef enum logic [1:0] {
    I2S_FMT_I2S  = 2'd0,
    I2S_FMT_LJ   = 2'd1,
    I2S_FMT_TDM  = 2'd2,
    I2S_FMT_RSVD = 2'd3
  } i2s_fmt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  // 8 x 32 x 2 = 512 MCLK per frame, i.e. 44.1 kHz from 22.5792 MHz.
  localparam int unsigned DEF_MCLK_PER_SCLK = 8;
  localparam int unsigned DEF_SLOT_BITS     = 32;
  localparam int unsigned DEF_NUM_SLOTS     = 2;

endpackage

// File: rtl/i2s_sclk_div.sv
// SCLK divider: MCLK down to a 50% duty bit clock plus rise/fall strobes.
// Ports:
//   clk         MCLK
//   rst_n       synchronous active-low reset
//   run_i       run enable; low clears counter, sclk and strobes
//   start_i     first enabled cycle: restart at the falling edge of bit 0
//   sclk_o      bit clock
//   sclk_rise_o one-cycle strobe with sclk 0->1
//   sclk_fall_o one-cycle strobe with sclk 1->0 (start of every bit)
//   wrap_o      divider is on its last count; the next edge is a fall
module i2s_sclk_div #(
  parameter int unsigned MCLK_PER_SCLK = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic start_i,
  output logic sclk_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic wrap_o
);

  localparam int unsigned CW = $clog2(MCLK_PER_SCLK);
  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(MCLK_PER_SCLK / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(MCLK_PER_SCLK - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (!run_i) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (start_i || (div_cnt_q == CNT_LAST)) begin
      // Both a fresh start and a wrap begin a new bit on a falling edge.
      div_cnt_d = '0;
      sclk_d    = 1'b0;
      fall_d    = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (div_cnt_q == CNT_HALF_M1) begin
        sclk_d = 1'b1;
        rise_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign sclk_rise_o = rise_q;
  assign sclk_fall_o = fall_q;
  assign wrap_o      = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/i2s_clk_gen.sv
// I2S/TDM bit-clock and frame-clock generator in the MCLK domain.
// Ports:
//   clk          MCLK, the only clock
//   rst_n        synchronous active-low reset
//   en           run enable; low forces idle with all outputs 0
//   fmt          framing select, taken only at frame boundaries
//   sclk         bit clock, 50% duty
//   lrck         word select / frame sync
//   sclk_rise    strobe with sclk 0->1
//   sclk_fall    strobe with sclk 1->0, start of every bit
//   frame_start  strobe on the fall that begins slot 0, bit 0
//   slot_idx     slot of the current bit
//   bit_idx      bit within slot, 0 = MSB
//
// state   | meaning
// ST_IDLE | disabled or in reset; all outputs and counters 0
// ST_RUN  | generating sclk/lrck, position advances on each fall
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned MCLK_PER_SCLK = DEF_MCLK_PER_SCLK,
  parameter int unsigned SLOT_BITS     = DEF_SLOT_BITS,
  parameter int unsigned NUM_SLOTS     = DEF_NUM_SLOTS,
  localparam int unsigned SW = $clog2(NUM_SLOTS),
  localparam int unsigned BW = $clog2(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  i2s_fmt_e      fmt,
  output logic          sclk,
  output logic          lrck,
  output logic          sclk_rise,
  output logic          sclk_fall,
  output logic          frame_start,
  output logic [SW-1:0] slot_idx,
  output logic [BW-1:0] bit_idx
);

  if ((MCLK_PER_SCLK < 2) || ((MCLK_PER_SCLK % 2) != 0)) begin : g_bad_mclk
    $error("i2s_clk_gen: MCLK_PER_SCLK must be even and >= 2");
  end
  if (SLOT_BITS < 2) begin : g_bad_slot_bits
    $error("i2s_clk_gen: SLOT_BITS must be >= 2");
  end
  if ((NUM_SLOTS < 2) || (NUM_SLOTS > 16) || ((NUM_SLOTS % 2) != 0)) begin : g_bad_num_slots
    $error("i2s_clk_gen: NUM_SLOTS must be even and within 2..16");
  end

  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_SLOTS - 1);
  localparam logic [SW-1:0] SLOT_HALF = SW'(NUM_SLOTS / 2);

  i2s_state_e    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] bit_q, bit_d;
  i2s_fmt_e      fmt_q, fmt_d;
  logic          lrck_q, lrck_d;
  logic          fs_q, fs_d;
  logic          div_wrap;

  // lrck for the bit that starts at (slot, bitp). I2S looks one bit
  // ahead so the word select leads the MSB of the next channel.
  function automatic logic lrck_of(logic [SW-1:0] slot, logic [BW-1:0] bitp,
                                   i2s_fmt_e f);
    logic [SW-1:0] slot_nx;
    logic          v;
    slot_nx = slot;
    if (bitp == BIT_LAST) begin
      slot_nx = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    end
    case (f)
      I2S_FMT_LJ:  v = (slot < SLOT_HALF);
      I2S_FMT_TDM: v = (slot == '0) && (bitp == '0);
      default:     v = (slot_nx >= SLOT_HALF);
    endcase
    return v;
  endfunction

  i2s_sclk_div #(
    .MCLK_PER_SCLK(MCLK_PER_SCLK)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (en),
    .start_i    (state_q == ST_IDLE),
    .sclk_o     (sclk),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall),
    .wrap_o     (div_wrap)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    fmt_d   = fmt_q;
    lrck_d  = lrck_q;
    fs_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      bit_d   = '0;
      fmt_d   = I2S_FMT_I2S;
      lrck_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
      slot_d  = '0;
      bit_d   = '0;
      fmt_d   = fmt;
      fs_d    = 1'b1;
      lrck_d  = lrck_of('0, '0, fmt);
    end else if (div_wrap) begin
      if (bit_q == BIT_LAST) begin
        bit_d = '0;
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          fs_d   = 1'b1;
          fmt_d  = fmt;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end else begin
        bit_d = bit_q + 1'b1;
      end
      lrck_d = lrck_of(slot_d, bit_d, fmt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      bit_q   <= '0;
      fmt_q   <= I2S_FMT_I2S;
      lrck_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      fmt_q   <= fmt_d;
      lrck_q  <= lrck_d;
      fs_q    <= fs_d;
    end
  end

  assign lrck        = lrck_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;

endmodule
